// File: rtl/tx_trn_arbiter_pkg.sv
// Shared definitions for the TRN transmit arbiter: state encodings, error bit
// indices and parameter defaults.
package tx_trn_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_GAP   = 3'b001,
    ST_OFFER = 3'b010,
    ST_BUSY  = 3'b100
  } arb_state_t;

  localparam int ERR_SPURIOUS = 0;
  localparam int ERR_MULTI    = 1;
  localparam int ERR_WATCHDOG = 2;

  localparam int DEF_OFFER_CYCLES = 4;
  localparam int DEF_MAX_HOLD     = 1024;
  localparam int WD_W             = 11;

endpackage

// File: rtl/tx_arb_watchdog.sv
// Ownership watchdog: counts BUSY cycles (saturating) and flags when MAX_HOLD is reached.
// Instantiated by tx_trn_arbiter only when TX_ARB_WATCHDOG_EN is defined.
module tx_arb_watchdog
  import tx_trn_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic trn_clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  output logic hit
);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge trn_clk) begin
    if (reset || start) begin
      wd_cnt <= '0;
    end else if (busy && (wd_cnt != '1)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires during the MAX_HOLD-th BUSY cycle so the sticky flag shows right after it.
  assign hit = busy && (wd_cnt >= WD_W'(MAX_HOLD - 1));

endmodule

// File: rtl/tx_trn_arbiter.sv
// Round-robin owner of the TRN TX interface using the my_turn / driving_interface handshake.
// Optional ownership watchdog compiled in with TX_ARB_WATCHDOG_EN.
//
// Handshake: my_turn[i] offers the bus to engine i; the engine takes it by raising
// driving_interface[i] (one cycle after seeing my_turn) and keeps it high for as long as
// it owns the bus. Dropping driving_interface[owner] releases the bus.
module tx_trn_arbiter
  import tx_trn_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int OFFER_CYCLES = DEF_OFFER_CYCLES,
  parameter int MAX_HOLD     = DEF_MAX_HOLD,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic               trn_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] driving_interface,
  output logic [NUM_REQ-1:0] my_turn,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               bus_busy,
  output logic [2:0]         arb_error,
  output arb_state_t         state_dbg
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || OFFER_CYCLES < 2 || OFFER_CYCLES > 15 ||
      MAX_HOLD < 1 || MAX_HOLD > 2047) begin : g_bad_params
    $error("tx_trn_arbiter: parameter out of range");
  end

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [IDX_W-1:0]   last, last_n;
  logic [IDX_W-1:0]   allowed;
  logic [3:0]         cnt, cnt_n;
  logic [NUM_REQ-1:0] my_turn_n;
  logic [IDX_W-1:0]   grant_n;
  logic               busy_n;
  logic [2:0]         err_set;
  logic               wd_hit;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state     <= ST_GAP;
      ptr       <= '0;
      owner     <= '0;
      last      <= '0;
      cnt       <= '0;
      my_turn   <= '0;
      grant_idx <= '0;
      bus_busy  <= 1'b0;
      arb_error <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      last      <= last_n;
      cnt       <= cnt_n;
      my_turn   <= my_turn_n;
      grant_idx <= grant_n;
      bus_busy  <= busy_n;
      arb_error <= arb_error | err_set;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    last_n    = last;
    cnt_n     = cnt;
    my_turn_n = my_turn;
    grant_n   = grant_idx;
    busy_n    = bus_busy;
    allowed   = last;
    case (state)
      ST_GAP: begin
        allowed = last;
        // An engine that saw its offer in the final OFFER cycle may still take here.
        if (driving_interface[last]) begin
          state_n   = ST_BUSY;
          owner_n   = last;
          grant_n   = last;
          busy_n    = 1'b1;
          my_turn_n = '0;
        end else begin
          state_n   = ST_OFFER;
          my_turn_n = onehot(ptr);
          last_n    = ptr;
          cnt_n     = '0;
        end
      end
      ST_OFFER: begin
        allowed = ptr;
        if (driving_interface[ptr]) begin
          state_n   = ST_BUSY;
          owner_n   = ptr;
          grant_n   = ptr;
          busy_n    = 1'b1;
          my_turn_n = '0;
        end else if (cnt == 4'(OFFER_CYCLES - 1)) begin
          state_n   = ST_GAP;
          my_turn_n = '0;
          ptr_n     = wrap_inc(ptr);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_BUSY: begin
        allowed = owner;
        if (!driving_interface[owner]) begin
          state_n = ST_GAP;
          busy_n  = 1'b0;
          ptr_n   = wrap_inc(owner);
        end
      end
      default: begin
        state_n   = ST_GAP;
        my_turn_n = '0;
        busy_n    = 1'b0;
      end
    endcase
  end

  always_comb begin
    err_set               = '0;
    err_set[ERR_SPURIOUS] = |(driving_interface & ~onehot(allowed));
    err_set[ERR_MULTI]    = ($countones(driving_interface) > 1);
    err_set[ERR_WATCHDOG] = wd_hit;
  end

`ifdef TX_ARB_WATCHDOG_EN
  tx_arb_watchdog #(
    .MAX_HOLD (MAX_HOLD)
  ) u_watchdog (
    .trn_clk (trn_clk),
    .reset   (reset),
    .start   ((state_n == ST_BUSY) && (state != ST_BUSY)),
    .busy    (state == ST_BUSY),
    .hit     (wd_hit)
  );
`else
  assign wd_hit = 1'b0;
`endif

  assign state_dbg = state;

endmodule
